p2s_tx: RTL and testbench

- Parallel-to-serial transmitter; sits directly upstream of the team's serial-to-parallel deserialiser (start/sin/pout/done).
- Accepts W-bit words on a valid/ready handshake and emits each word MSB-first on `sout`.
- Pulses `start` coincident with the MSB, so the deserialiser's shift register and one-hot counter line up with the word boundary.
- Optional idle gap between words.

---
 rtl/p2s_pkg.sv | 17 +
 rtl/p2s_tx.sv | 141 ++++++++++++++
 tb/tb_p2s_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
//   p2s_state_t : FSM state encoding (IDLE, SHIFT, GAP)
//   cnt_width() : counter width for a counter covering n states, never below 1 bit
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } p2s_state_t;

    // $clog2 of 1 is 0; a zero-width counter is not legal, so clamp to 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : p2s_pkg

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter feeding the serial-to-parallel deserialiser.
// Accepts a W-bit word on a valid/ready handshake, sends it MSB-first on sout
// and pulses start together with the MSB. GAP idle cycles follow each word.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   din        : parallel word, sampled only on the transfer edge
//   din_valid  : din holds a valid word
//   din_ready  : combinational from state; block can accept din this cycle
//   start      : registered one-cycle pulse aligned with the MSB
//   sout       : registered serial data, MSB first
//   busy       : registered, high while shifting or while a gap is running
module p2s_tx #(
    parameter int unsigned W   = 4,
    parameter int unsigned GAP = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         start,
    output logic         sout,
    output logic         busy
);

    import p2s_pkg::p2s_state_t;
    import p2s_pkg::IDLE;
    import p2s_pkg::SHIFT;
    import p2s_pkg::cnt_width;

    localparam int unsigned    BCW      = cnt_width(W);
    localparam int unsigned    GCW      = cnt_width(GAP + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit             HAS_GAP  = (GAP > 0);

    p2s_state_t     state;
    p2s_state_t     state_next;
    logic [W-1:0]   shreg;
    logic [BCW-1:0] bit_cnt;
    logic [GCW-1:0] gap_cnt;

    logic           xfer_c;
    logic           last_bit_c;
    logic           gap_done_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer_c) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit_c) begin
                    if (HAS_GAP) begin
                        state_next = p2s_pkg::GAP;
                    end else if (!xfer_c) begin
                        state_next = IDLE;
                    end
                end
            end
            p2s_pkg::GAP: begin
                if (gap_done_c) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Combinational outputs and decode: ready in IDLE, and on the last bit
    // when no gap follows so words can run back-to-back.
    always_comb begin
        last_bit_c = (state == SHIFT) && (bit_cnt == BIT_LAST);
        gap_done_c = (state == p2s_pkg::GAP) && (gap_cnt == GAP_LAST);
        din_ready  = (state == IDLE) || (last_bit_c && !HAS_GAP);
        xfer_c     = din_valid && din_ready;
    end

    // Datapath: shift register, counters and registered outputs.
    // shreg holds the word pre-shifted so shreg[W-2] is always the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start   <= 1'b0;
            sout    <= 1'b0;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            start <= 1'b0;
            if (xfer_c) begin
                shreg   <= din;
                bit_cnt <= '0;
                start   <= 1'b1;
                sout    <= din[W-1];
                busy    <= 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        if (last_bit_c) begin
                            sout <= 1'b0;
                            if (HAS_GAP) begin
                                gap_cnt <= '0;
                            end else begin
                                busy <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                            shreg   <= shreg << 1;
                            sout    <= shreg[W-2];
                        end
                    end
                    p2s_pkg::GAP: begin
                        gap_cnt <= gap_cnt + GCW'(1);
                        if (gap_done_c) begin
                            busy <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule : p2s_tx

// File: tb/tb_p2s_tx.sv
// Testbench for p2s_tx: directed timing checks on W=4 (GAP=0 and GAP=2)
// instances plus a random W=8 loopback into a behavioural deserialiser.
module tb_p2s_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // W=4, GAP=0
    logic [3:0] din4 = '0;
    logic v4 = 1'b0, r4, st4, so4, b4;
    // W=4, GAP=2
    logic [3:0] ding = '0;
    logic vg = 1'b0, rg, stg, sog, bg;
    // W=8, GAP=0 (loopback)
    logic [7:0] din8 = '0;
    logic v8 = 1'b0, r8, st8, so8, b8;

    p2s_tx #(.W(4), .GAP(0)) u4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(v4),
        .din_ready(r4), .start(st4), .sout(so4), .busy(b4)
    );
    p2s_tx #(.W(4), .GAP(2)) ug (
        .clk(clk), .rst_n(rst_n), .din(ding), .din_valid(vg),
        .din_ready(rg), .start(stg), .sout(sog), .busy(bg)
    );
    p2s_tx #(.W(8), .GAP(0)) u8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(v8),
        .din_ready(r8), .start(st8), .sout(so8), .busy(b8)
    );

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural deserialiser: collects 8 bits starting at each start pulse.
    logic [7:0]  q_word[$];
    int unsigned q_start[$];
    bit          lb_on = 1'b0;
    int          rx_cnt = 0;
    int          rx_count = 0;
    logic [7:0]  rx_acc = '0;

    always @(negedge clk) begin
        if (lb_on && rst_n) begin
            if (st8) begin
                chk("lb_start_boundary", (rx_cnt == 0) ? 1 : 0, 1);
                if (q_start.size() == 0) chk("lb_spurious_start", 0, 1);
                else chk("lb_start_latency", cyc, q_start.pop_front());
                rx_acc = 8'(so8);
                rx_cnt = 1;
            end else if (rx_cnt != 0) begin
                rx_acc = {rx_acc[6:0], so8};
                rx_cnt++;
            end else begin
                chk("lb_idle_sout", so8, 0);
            end
            if (rx_cnt != 0) chk("lb_busy", b8, 1);
            if (rx_cnt == 8) begin
                if (q_word.size() == 0) chk("lb_extra_word", 0, 1);
                else chk("lb_word", rx_acc, q_word.pop_front());
                rx_count++;
                rx_cnt = 0;
            end
        end
    end

    initial begin
        logic [3:0] w1;
        logic [7:0] seq2;
        logic [7:0] w8;
        bit got;

        // Reset state
        #2;
        chk("rst_start4", st4, 0); chk("rst_sout4", so4, 0); chk("rst_busy4", b4, 0);
        chk("rst_ready4", r4, 1);
        chk("rst_startg", stg, 0); chk("rst_soutg", sog, 0); chk("rst_busyg", bg, 0);
        chk("rst_start8", st8, 0); chk("rst_sout8", so8, 0); chk("rst_busy8", b8, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Stalled upstream in IDLE
        repeat (20) begin
            @(negedge clk);
            chk("stall_ready", r4, 1); chk("stall_start", st4, 0);
            chk("stall_sout", so4, 0); chk("stall_busy", b4, 0);
        end

        // Single word 1011, transfer at edge 0
        @(posedge clk); #1;
        w1 = 4'b1011; din4 = w1; v4 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin v4 = 1'b0; din4 = 4'b0100; end
            @(negedge clk);
            chk("one_start", st4, (c == 1) ? 1 : 0);
            chk("one_sout", so4, (c <= 4) ? 32'(w1[4-c]) : 0);
            chk("one_busy", b4, (c <= 4) ? 1 : 0);
            chk("one_ready", r4, (c >= 4) ? 1 : 0);
        end

        // Back-to-back A then 5 with valid held
        @(posedge clk); #1;
        seq2 = 8'hA5; din4 = 4'hA; v4 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 1) din4 = 4'h5;
            if (c == 5) begin v4 = 1'b0; din4 = 4'hF; end
            @(negedge clk);
            chk("b2b_start", st4, (c == 1 || c == 5) ? 1 : 0);
            chk("b2b_sout", so4, (c <= 8) ? 32'(seq2[8-c]) : 0);
            chk("b2b_busy", b4, (c <= 8) ? 1 : 0);
        end

        // GAP=2: din_ready stays low through the gap, so the second word is
        // accepted from IDLE on cycle 7 and starts on cycle 8.
        @(posedge clk); #1;
        ding = 4'hF; vg = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 8) begin vg = 1'b0; ding = 4'h0; end
            @(negedge clk);
            chk("gap_start", stg, (c == 1 || c == 8) ? 1 : 0);
            chk("gap_sout", sog, ((c >= 1 && c <= 4) || (c >= 8 && c <= 11)) ? 1 : 0);
            chk("gap_busy", bg, ((c >= 1 && c <= 6) || (c >= 8 && c <= 13)) ? 1 : 0);
            chk("gap_ready", rg, (c == 7 || c == 14) ? 1 : 0);
        end

        // Reset during the 2nd bit of 1100
        @(posedge clk); #1;
        din4 = 4'hC; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        chk("mid_pre_sout", so4, 1); chk("mid_pre_busy", b4, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", st4, 0); chk("mid_rst_sout", so4, 0);
        chk("mid_rst_busy", b4, 0); chk("mid_rst_ready", r4, 1);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_start", st4, 0); chk("post_rst_sout", so4, 0);
            chk("post_rst_busy", b4, 0);
        end

        // Random loopback, W=8
        lb_on = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                din8 = 8'($urandom);
            end
            w8 = 8'($urandom);
            din8 = w8;
            v8 = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (r8) begin
                    q_word.push_back(w8);
                    q_start.push_back(cyc + 1);
                    got = 1'b1;
                end
                @(posedge clk); #1;
            end
            chk("lb_accept", 32'(got), 1);
            v8 = 1'b0;
            din8 = 8'($urandom);
        end
        for (int t = 0; t < 100 && q_word.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        chk("lb_drain", q_word.size(), 0);
        chk("lb_count", rx_count, 256);
        lb_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_p2s_tx
